// File: rtl/cost_monitor_pkg.sv
// Shared types and constants for the training-loop cost monitor.
package cost_monitor_pkg;

    // Supervisor FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        CAPTURE = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Reason the run ended
    typedef enum logic [1:0] {
        STOP_NONE  = 2'b00,
        STOP_CONV  = 2'b01,
        STOP_MAXEP = 2'b10,
        STOP_STALL = 2'b11
    } stop_t;

    // Default fixed-point format (WIDTH=32, FRAC=24)
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_FRAC  = 24;
    localparam logic [DEF_WIDTH-1:0] ONE     = DEF_WIDTH'(1) << DEF_FRAC;
    localparam logic [DEF_WIDTH-1:0] MAX_POS = 32'h7FFF_FFFF;

endpackage

// File: rtl/cost_monitor_tracker.sv
// Tracks the best epoch cost seen in a run and the run of non-improving epochs.
module cost_tracker
    import cost_monitor_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PATIENCE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             judge,
    input  logic [WIDTH-1:0] cost,
    output logic             stall_c
);

    localparam int unsigned SW     = (PATIENCE < 2) ? 1 : $clog2(PATIENCE + 1);
    localparam int unsigned PAT_M1 = (PATIENCE == 0) ? 0 : PATIENCE - 1;
    localparam logic [WIDTH-1:0] MAX_POS_W = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0] best_cost;
    logic [SW-1:0]    stall_cnt;
    logic             improve;

    // Strict signed improvement; an equal cost counts as a stall
    assign improve = $signed(cost) < $signed(best_cost);

    // This judgement would bring the non-improving streak up to PATIENCE
    assign stall_c = (PATIENCE != 0) && !improve && (stall_cnt == SW'(PAT_M1));

    // Best cost and streak update once per judged epoch; the streak saturates
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            best_cost <= MAX_POS_W;
            stall_cnt <= '0;
        end else if (judge) begin
            if (improve) begin
                best_cost <= cost;
                stall_cnt <= '0;
            end else if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/cost_monitor.sv
// Training-loop supervisor downstream of cost_acc: epoch framing, capture and stop decision.
module cost_monitor
    import cost_monitor_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAC      = 24,
    parameter int unsigned N_SAMPLES = 4,
    parameter int unsigned SCW       = 8,
    parameter int unsigned MAX_EPOCH = 1000,
    parameter int unsigned EPW       = 16,
    parameter int unsigned PATIENCE  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_cost,
    input  logic [WIDTH-1:0] i_threshold,
    output logic             o_acc_en,
    output logic [WIDTH-1:0] o_epoch_cost,
    output logic             o_epoch_valid,
    output logic [EPW-1:0]   o_epoch_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_stop_code
);

    // Reject parameter sets the counters or fixed-point format cannot represent
    if (N_SAMPLES < 1 || MAX_EPOCH < 1 || FRAC >= WIDTH ||
        N_SAMPLES >= (1 << SCW) || MAX_EPOCH >= (1 << EPW)) begin : g_param_check
        $error("cost_monitor: illegal parameter combination");
    end

    state_t           state, state_d;
    logic [SCW-1:0]   sample_cnt, sample_cnt_d;
    logic [EPW-1:0]   epoch_cnt_d, epoch_inc;
    logic [WIDTH-1:0] epoch_cost_d;
    logic             epoch_valid_d, done_d;
    logic [1:0]       stop_code_d;
    logic             trk_clr, trk_judge, stall_c;
    logic             conv_c, maxep_c;

    assign epoch_inc = o_epoch_cnt + EPW'(1);
    assign conv_c    = $signed(o_epoch_cost) < $signed(i_threshold);
    assign maxep_c   = (epoch_inc == EPW'(MAX_EPOCH));

    // First sample of an epoch overwrites cost_acc's stale total
    assign o_acc_en = (state == RUN) && (sample_cnt != '0);
    assign o_busy   = (state == RUN) || (state == CAPTURE) || (state == CHECK);

    cost_tracker #(
        .WIDTH    (WIDTH),
        .PATIENCE (PATIENCE)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .clr     (trk_clr),
        .judge   (trk_judge),
        .cost    (o_epoch_cost),
        .stall_c (stall_c)
    );

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d       = state;
        sample_cnt_d  = sample_cnt;
        epoch_cnt_d   = o_epoch_cnt;
        epoch_cost_d  = o_epoch_cost;
        epoch_valid_d = 1'b0;
        done_d        = o_done;
        stop_code_d   = o_stop_code;
        trk_clr       = 1'b0;
        trk_judge     = 1'b0;

        case (state)
            IDLE: begin
                sample_cnt_d = '0;
                epoch_cnt_d  = '0;
                epoch_cost_d = '0;
                stop_code_d  = STOP_NONE;
                done_d       = 1'b0;
                trk_clr      = 1'b1;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (i_valid) begin
                    if (sample_cnt == SCW'(N_SAMPLES - 1)) begin
                        sample_cnt_d = '0;
                        state_d      = CAPTURE;
                    end else begin
                        sample_cnt_d = sample_cnt + SCW'(1);
                    end
                end
            end
            CAPTURE: begin
                // cost_acc's registered total now includes the last sample
                epoch_cost_d  = i_cost;
                epoch_valid_d = 1'b1;
                state_d       = CHECK;
            end
            CHECK: begin
                trk_judge   = 1'b1;
                epoch_cnt_d = epoch_inc;
                if (conv_c) begin
                    stop_code_d = STOP_CONV;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else if (maxep_c) begin
                    stop_code_d = STOP_MAXEP;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else if (stall_c) begin
                    stop_code_d = STOP_STALL;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d     = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    sample_cnt_d = '0;
                    epoch_cnt_d  = '0;
                    epoch_cost_d = '0;
                    stop_code_d  = STOP_NONE;
                    done_d       = 1'b0;
                    trk_clr      = 1'b1;
                    state_d      = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            sample_cnt    <= '0;
            o_epoch_cnt   <= '0;
            o_epoch_cost  <= '0;
            o_epoch_valid <= 1'b0;
            o_done        <= 1'b0;
            o_stop_code   <= STOP_NONE;
        end else begin
            state         <= state_d;
            sample_cnt    <= sample_cnt_d;
            o_epoch_cnt   <= epoch_cnt_d;
            o_epoch_cost  <= epoch_cost_d;
            o_epoch_valid <= epoch_valid_d;
            o_done        <= done_d;
            o_stop_code   <= stop_code_d;
        end
    end

endmodule

// File: tb/tb_cost_monitor.sv
// Bench for cost_monitor: three instances (default, PATIENCE=2, MAX_EPOCH=3/PATIENCE=0)
// share one stimulus stream; cost_acc and the stop rules are modelled in the bench.
module tb_cost_monitor;

    localparam int NI = 3;
    localparam logic [31:0] THR = 32'h0040_0000;
    localparam int THR_I = 32'h0040_0000;
    localparam int MAXP = 32'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rst, start, i_valid;
    logic [31:0] i_cost, i_threshold;

    logic        acc_en      [NI];
    logic [31:0] epoch_cost  [NI];
    logic        epoch_valid [NI];
    logic [15:0] epoch_cnt   [NI];
    logic        busy        [NI];
    logic        done        [NI];
    logic [1:0]  stop_code   [NI];

    int total = 0;
    int bad   = 0;

    // Observations from the most recent epoch
    logic        en_obs   [NI][4];
    logic        busy_cap [NI];
    logic        v_obs    [NI];
    logic        v2_obs   [NI];
    logic [31:0] cost_obs [NI];
    logic [15:0] cnt_obs  [NI];
    logic        done_obs [NI];
    logic        busy_obs [NI];
    logic [1:0]  code_obs [NI];

    // Reference model state per instance
    int m_best [NI];
    int m_stall[NI];
    int m_ep   [NI];
    int m_code [NI];
    int m_last [NI];
    bit m_run  [NI];
    bit m_done [NI];
    bit m_run0 [NI];
    bit m_judged[NI];

    always #5 clk = ~clk;

    cost_monitor u_def (
        .clk(clk), .rst(rst), .start(start), .i_valid(i_valid), .i_cost(i_cost),
        .i_threshold(i_threshold), .o_acc_en(acc_en[0]), .o_epoch_cost(epoch_cost[0]),
        .o_epoch_valid(epoch_valid[0]), .o_epoch_cnt(epoch_cnt[0]), .o_busy(busy[0]),
        .o_done(done[0]), .o_stop_code(stop_code[0]));

    cost_monitor #(.PATIENCE(2)) u_pat2 (
        .clk(clk), .rst(rst), .start(start), .i_valid(i_valid), .i_cost(i_cost),
        .i_threshold(i_threshold), .o_acc_en(acc_en[1]), .o_epoch_cost(epoch_cost[1]),
        .o_epoch_valid(epoch_valid[1]), .o_epoch_cnt(epoch_cnt[1]), .o_busy(busy[1]),
        .o_done(done[1]), .o_stop_code(stop_code[1]));

    cost_monitor #(.MAX_EPOCH(3), .PATIENCE(0)) u_max3 (
        .clk(clk), .rst(rst), .start(start), .i_valid(i_valid), .i_cost(i_cost),
        .i_threshold(i_threshold), .o_acc_en(acc_en[2]), .o_epoch_cost(epoch_cost[2]),
        .o_epoch_valid(epoch_valid[2]), .o_epoch_cnt(epoch_cnt[2]), .o_busy(busy[2]),
        .o_done(done[2]), .o_stop_code(stop_code[2]));

    function automatic int pat_of(input int m);
        return (m == 0) ? 8 : (m == 1) ? 2 : 0;
    endfunction

    function automatic int maxep_of(input int m);
        return (m == 2) ? 3 : 1000;
    endfunction

    function automatic void model_clear(input int m);
        m_best[m] = MAXP; m_stall[m] = 0; m_ep[m] = 0; m_code[m] = 0; m_last[m] = 0;
        m_done[m] = 1'b0;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < NI; m++) begin model_clear(m); m_run[m] = 1'b0; end
    endfunction

    // A start is only taken by an instance that is not mid-run
    function automatic void model_start();
        for (int m = 0; m < NI; m++)
            if (!m_run[m]) begin model_clear(m); m_run[m] = 1'b1; end
    endfunction

    // Judge one epoch cost against the stop rules, in priority order
    function automatic void model_epoch(input int c);
        for (int m = 0; m < NI; m++) begin
            m_judged[m] = m_run[m];
            if (m_run[m]) begin
                m_ep[m]++;
                m_last[m] = c;
                if (c < m_best[m]) begin m_best[m] = c; m_stall[m] = 0; end
                else m_stall[m]++;
                if (c < THR_I)                                      m_code[m] = 1;
                else if (m_ep[m] == maxep_of(m))                    m_code[m] = 2;
                else if (pat_of(m) != 0 && m_stall[m] == pat_of(m)) m_code[m] = 3;
                else                                                m_code[m] = 0;
                if (m_code[m] != 0) begin m_run[m] = 1'b0; m_done[m] = 1'b1; end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; i_valid = 1'b0; i_cost = '0;
        tick();
        rst = 1'b1;
        model_reset();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_start();
    endtask

    // Feed one epoch whose cost_acc total is tot; cost_acc restarts on sample 0
    task automatic run_epoch(input int tot, input int gap, input int start_at);
        int s [4];
        int acc;
        for (int m = 0; m < NI; m++) m_run0[m] = m_run[m];
        for (int k = 0; k < 3; k++) s[k] = int'($urandom_range(32'h0010_0000, 0));
        s[3] = tot - s[0] - s[1] - s[2];
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) repeat (gap) begin i_valid = 1'b0; tick(); end
            i_valid = 1'b1;
            start = (k == start_at);
            @(negedge clk);
            for (int m = 0; m < NI; m++) en_obs[m][k] = acc_en[m];
            tick();
            acc = (k == 0) ? s[k] : acc + s[k];
            i_cost = 32'(acc);
            start = 1'b0;
        end
        i_valid = 1'b0;
        model_epoch(tot);
        @(negedge clk);
        for (int m = 0; m < NI; m++) busy_cap[m] = busy[m];
        tick();
        @(negedge clk);
        for (int m = 0; m < NI; m++) begin v_obs[m] = epoch_valid[m]; cost_obs[m] = epoch_cost[m]; end
        tick();
        @(negedge clk);
        for (int m = 0; m < NI; m++) begin
            v2_obs[m] = epoch_valid[m]; cnt_obs[m] = epoch_cnt[m]; done_obs[m] = done[m];
            busy_obs[m] = busy[m]; code_obs[m] = stop_code[m];
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            start = 1'($urandom); i_valid = 1'($urandom); i_cost = $urandom;
            tick();
            @(negedge clk);
            for (int m = 0; m < NI; m++) begin
                total++;
                if ({acc_en[m], epoch_cost[m], epoch_valid[m], epoch_cnt[m], busy[m], done[m], stop_code[m]} !== '0) begin
                    bad++;
                    $display("FAIL reset_outputs inst=%0d cyc=%0d got en=%b cost=%h v=%b cnt=%0d busy=%b done=%b code=%b exp all 0",
                             m, c, acc_en[m], epoch_cost[m], epoch_valid[m], epoch_cnt[m], busy[m], done[m], stop_code[m]);
                end
            end
        end
        start = 1'b1; i_valid = 1'b0; i_cost = '0;
        tick();
        rst = 1'b1; start = 1'b0;
        tick();
        @(negedge clk);
        for (int m = 0; m < NI; m++) begin
            total++;
            if (busy[m] !== 1'b0) begin bad++; $display("FAIL reset_start_ignored inst=%0d busy got=%b exp=0", m, busy[m]); end
        end
        model_reset();
        tick();
    endtask

    task automatic test_one_epoch();
        do_reset(); do_start();
        run_epoch(32'h0080_0000, 0, -1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (en_obs[0][k] !== 1'(k != 0)) begin bad++; $display("FAIL one_acc_en s%0d got=%b exp=%b", k, en_obs[0][k], k != 0); end
        end
        total++; if (busy_cap[0] !== 1'b1) begin bad++; $display("FAIL one_busy_capture got=%b exp=1", busy_cap[0]); end
        total++; if (v_obs[0] !== 1'b1) begin bad++; $display("FAIL one_epoch_valid got=%b exp=1", v_obs[0]); end
        total++; if (cost_obs[0] !== 32'h0080_0000) begin bad++; $display("FAIL one_epoch_cost got=%h exp=00800000", cost_obs[0]); end
        total++; if (v2_obs[0] !== 1'b0) begin bad++; $display("FAIL one_valid_pulse got=%b exp=0", v2_obs[0]); end
        total++; if (cnt_obs[0] !== 16'd1) begin bad++; $display("FAIL one_epoch_cnt got=%0d exp=1", cnt_obs[0]); end
        total++; if (done_obs[0] !== 1'b0 || busy_obs[0] !== 1'b1) begin bad++; $display("FAIL one_back_to_run done=%b busy=%b exp 0/1", done_obs[0], busy_obs[0]); end
    endtask

    task automatic test_convergence();
        do_reset(); do_start();
        run_epoch(32'h0080_0000, 0, -1);
        run_epoch(32'h0030_0000, 0, -1);
        total++; if (code_obs[0] !== 2'b01) begin bad++; $display("FAIL conv_code got=%b exp=01", code_obs[0]); end
        total++; if (done_obs[0] !== 1'b1 || busy_obs[0] !== 1'b0) begin bad++; $display("FAIL conv_done done=%b busy=%b exp 1/0", done_obs[0], busy_obs[0]); end
        total++; if (cnt_obs[0] !== 16'd2) begin bad++; $display("FAIL conv_cnt got=%0d exp=2", cnt_obs[0]); end
        do_start();
        @(negedge clk);
        total++;
        if (epoch_cnt[0] !== 16'd0 || done[0] !== 1'b0 || busy[0] !== 1'b1 || stop_code[0] !== 2'b00) begin
            bad++; $display("FAIL restart_from_done cnt=%0d done=%b busy=%b code=%b exp 0/0/1/00", epoch_cnt[0], done[0], busy[0], stop_code[0]);
        end
        tick();
        run_epoch(32'h0040_0000, 0, -1);
        total++; if (code_obs[0] !== 2'b00 || done_obs[0] !== 1'b0) begin bad++; $display("FAIL conv_equal_thr code=%b done=%b exp 00/0", code_obs[0], done_obs[0]); end
        total++; if (cnt_obs[0] !== 16'd1) begin bad++; $display("FAIL conv_equal_cnt got=%0d exp=1", cnt_obs[0]); end
    endtask

    task automatic test_stall();
        do_reset(); do_start();
        run_epoch(32'h0080_0000, 0, -1);
        run_epoch(32'h0090_0000, 0, -1);
        total++; if (code_obs[1] !== 2'b00 || done_obs[1] !== 1'b0) begin bad++; $display("FAIL stall_early code=%b done=%b exp 00/0", code_obs[1], done_obs[1]); end
        run_epoch(32'h0080_0000, 0, -1);
        total++; if (code_obs[1] !== 2'b11) begin bad++; $display("FAIL stall_code got=%b exp=11", code_obs[1]); end
        total++; if (cnt_obs[1] !== 16'd3 || done_obs[1] !== 1'b1) begin bad++; $display("FAIL stall_cnt cnt=%0d done=%b exp 3/1", cnt_obs[1], done_obs[1]); end
        total++; if (code_obs[0] !== 2'b00 || done_obs[0] !== 1'b0) begin bad++; $display("FAIL stall_pat8 code=%b done=%b exp 00/0", code_obs[0], done_obs[0]); end
    endtask

    task automatic test_max_epochs();
        do_reset(); do_start();
        run_epoch(32'h00A0_0000, 0, -1);
        run_epoch(32'h0090_0000, 0, -1);
        total++; if (done_obs[2] !== 1'b0) begin bad++; $display("FAIL max_early done got=%b exp=0", done_obs[2]); end
        run_epoch(32'h0080_0000, 0, -1);
        total++; if (code_obs[2] !== 2'b10) begin bad++; $display("FAIL max_code got=%b exp=10", code_obs[2]); end
        total++; if (cnt_obs[2] !== 16'd3 || done_obs[2] !== 1'b1) begin bad++; $display("FAIL max_cnt cnt=%0d done=%b exp 3/1", cnt_obs[2], done_obs[2]); end
        do_start();
        run_epoch(32'h00A0_0000, 0, -1);
        run_epoch(32'h0090_0000, 0, -1);
        run_epoch(32'h0010_0000, 0, -1);
        total++; if (code_obs[2] !== 2'b01 || cnt_obs[2] !== 16'd3) begin bad++; $display("FAIL max_conv_priority code=%b cnt=%0d exp 01/3", code_obs[2], cnt_obs[2]); end
    endtask

    task automatic test_gaps_abort();
        do_reset(); do_start();
        run_epoch(32'h0050_0000, 2, 2);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (en_obs[0][k] !== 1'(k != 0)) begin bad++; $display("FAIL gap_acc_en s%0d got=%b exp=%b", k, en_obs[0][k], k != 0); end
        end
        total++; if (cost_obs[0] !== 32'h0050_0000 || v_obs[0] !== 1'b1) begin bad++; $display("FAIL gap_cost got=%h v=%b exp 00500000/1", cost_obs[0], v_obs[0]); end
        total++; if (cnt_obs[0] !== 16'd1) begin bad++; $display("FAIL gap_start_ignored cnt got=%0d exp=1", cnt_obs[0]); end
        i_valid = 1'b1; tick(); tick(); i_valid = 1'b0;
        rst = 1'b0; tick(); rst = 1'b1;
        model_reset();
        @(negedge clk);
        total++;
        if (busy[0] !== 1'b0 || epoch_cnt[0] !== 16'd0 || acc_en[0] !== 1'b0 || epoch_cost[0] !== 32'd0) begin
            bad++; $display("FAIL abort_reset busy=%b cnt=%0d en=%b cost=%h exp all 0", busy[0], epoch_cnt[0], acc_en[0], epoch_cost[0]);
        end
        tick();
        do_start();
        run_epoch(32'h0060_0000, 1, -1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (en_obs[0][k] !== 1'(k != 0)) begin bad++; $display("FAIL abort_acc_en s%0d got=%b exp=%b", k, en_obs[0][k], k != 0); end
        end
        total++; if (cost_obs[0] !== 32'h0060_0000 || cnt_obs[0] !== 16'd1) begin bad++; $display("FAIL abort_epoch cost=%h cnt=%0d exp 00600000/1", cost_obs[0], cnt_obs[0]); end
    endtask

    task automatic test_random();
        int tot, prev;
        for (int r = 0; r < 3; r++) begin
            do_reset(); do_start();
            prev = 32'h0080_0000;
            for (int e = 0; e < 12; e++) begin
                if (!m_run[0] && !m_run[1] && !m_run[2]) do_start();
                tot = ($urandom_range(3, 0) == 0) ? prev : int'($urandom_range(32'h00C0_0000, 32'h0020_0000));
                prev = tot;
                run_epoch(tot, int'($urandom_range(2, 0)), -1);
                for (int m = 0; m < NI; m++) begin
                    for (int k = 0; k < 4; k++) begin
                        total++;
                        if (en_obs[m][k] !== 1'(m_run0[m] && k != 0)) begin
                            bad++; $display("FAIL rnd_acc_en inst=%0d ep=%0d s%0d got=%b exp=%b", m, e, k, en_obs[m][k], m_run0[m] && k != 0);
                        end
                    end
                    total++;
                    if (busy_cap[m] !== m_run0[m] || v_obs[m] !== m_judged[m] || v2_obs[m] !== 1'b0) begin
                        bad++; $display("FAIL rnd_handshake inst=%0d ep=%0d busy=%b v=%b v2=%b exp %b/%b/0", m, e, busy_cap[m], v_obs[m], v2_obs[m], m_run0[m], m_judged[m]);
                    end
                    total++;
                    if (cost_obs[m] !== 32'(m_last[m]) || cnt_obs[m] !== 16'(m_ep[m])) begin
                        bad++; $display("FAIL rnd_cost_cnt inst=%0d ep=%0d cost=%h cnt=%0d exp %h/%0d", m, e, cost_obs[m], cnt_obs[m], m_last[m], m_ep[m]);
                    end
                    total++;
                    if (code_obs[m] !== 2'(m_code[m]) || done_obs[m] !== m_done[m] || busy_obs[m] !== m_run[m]) begin
                        bad++; $display("FAIL rnd_stop inst=%0d ep=%0d code=%b done=%b busy=%b exp %0d/%b/%b", m, e, code_obs[m], done_obs[m], busy_obs[m], m_code[m], m_done[m], m_run[m]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; i_valid = 1'b0; i_cost = '0; i_threshold = THR;
        model_reset();
        test_reset();
        test_one_epoch();
        test_convergence();
        test_stall();
        test_max_epochs();
        test_gaps_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/cost_monitor.md
Name: cost_monitor

Overview:
- Training-loop supervisor placed directly downstream of cost_acc.
- Drives cost_acc's `en` so the accumulator clears on the first sample of each epoch.
- Captures the per-epoch accumulated cost, counts samples and epochs, and decides when training stops: converged, epoch limit reached, or stalled with no improvement.

Parameters:
- WIDTH, 32, data width; signed fixed point.
- FRAC, 24, fractional bits (1.0 = 0x01000000).
- N_SAMPLES, 4, samples per epoch; must be ≥1.
- SCW, 8, sample counter width.
- MAX_EPOCH, 1000, epoch limit; must be ≥1.
- EPW, 16, epoch counter width.
- PATIENCE, 8, consecutive non-improving epochs before stall stop; 0 disables stall stop.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a training run (one-cycle pulse)
- i_valid  in  1  a sample's errors are presented to cost_acc this cycle
- i_cost  in  WIDTH  accumulated cost from cost_acc output
- i_threshold  in  WIDTH  convergence threshold; held stable during a run
- o_acc_en  out  1  to cost_acc `en`
- o_epoch_cost  out  WIDTH  last captured epoch cost
- o_epoch_valid  out  1  one-cycle pulse when a new epoch cost is judged
- o_epoch_cnt  out  EPW  completed epochs in this run
- o_busy  out  1  run in progress
- o_done  out  1  run finished; held until start or reset
- o_stop_code  out  2  00 none, 01 converged, 10 max epochs, 11 stalled

Behaviour:
- Reset (rst=0 at clk edge):
  - state IDLE; all outputs 0.
  - Internal sample_cnt=0, stall_cnt=0, best_cost=MAX_POS.
  - Applies in any state and aborts a run mid-epoch.
- Upstream contract: cost_acc adds every cycle, so the error lines must be zero whenever i_valid=0.
- o_acc_en = 1 only when state=RUN and sample_cnt≠0; otherwise 0. The first sample of every epoch therefore overwrites the stale total.
- IDLE:
  - start=1 → RUN.
  - Clear epoch_cnt, sample_cnt, stall_cnt, o_epoch_cost and o_stop_code; best_cost=MAX_POS.
- RUN:
  - Each i_valid increments sample_cnt.
  - On i_valid with sample_cnt=N_SAMPLES-1: sample_cnt←0 and go to CAPTURE.
  - Gaps in i_valid are allowed; start is ignored.
- CAPTURE (last sample at cycle t, CAPTURE at t+1):
  - o_epoch_cost ← i_cost. cost_acc's registered output now contains the last sample.
  - → CHECK.
- CHECK (t+2):
  - o_epoch_valid=1; epoch_cnt ← epoch_cnt+1.
  - Improvement: if o_epoch_cost < best_cost (signed), best_cost ← o_epoch_cost and stall_cnt←0; else stall_cnt+1.
  - Stop conditions, in priority order:
    - converged: o_epoch_cost < i_threshold (strict, signed).
    - max epochs: new epoch_cnt = MAX_EPOCH.
    - stalled: PATIENCE≠0 and new stall_cnt = PATIENCE.
  - Any condition true → DONE, o_stop_code set. Otherwise → RUN.
- DONE (from t+3):
  - o_done=1, o_busy=0. i_valid is ignored.
  - start → clear as in IDLE, go to RUN, o_done←0.
- o_busy = 1 in RUN, CAPTURE, CHECK.
- i_valid during CAPTURE/CHECK is a protocol violation: it is ignored and not counted. Upstream stalls at epoch boundary for 2 cycles.
- Counter widths: epoch_cnt does not wrap, because MAX_EPOCH stop precedes overflow; SCW and EPW must hold N_SAMPLES and MAX_EPOCH.
- All outputs registered except o_acc_en and o_busy, which are decoded from state and sample_cnt.

Decomposition:
- Package cost_monitor_pkg:
  - state encoding IDLE/RUN/CAPTURE/CHECK/DONE
  - stop codes STOP_NONE/CONV/MAXEP/STALL
  - fixed-point constants ONE = 1<<FRAC, MAX_POS = 0x7FFFFFFF
- One sub-module, cost_tracker:
  - holds best_cost and stall_cnt, computes improve/stall flags.
  - instantiated by the FSM/counter top.

Test Plan (N_SAMPLES=4, threshold 0x00400000; bench models cost_acc):
- Reset: hold rst=0 three cycles with random inputs → all outputs 0, o_acc_en=0. Start at the same edge as rst=0 → stays IDLE.
- One epoch: start, 4 back-to-back valid samples with cost model total 0x00800000 → o_acc_en 0,1,1,1; o_epoch_valid 2 cycles after last sample; o_epoch_cost=0x00800000, o_epoch_cnt=1, o_done=0, return to RUN.
- Convergence: second epoch total 0x00300000 → o_stop_code=01, o_done=1 three cycles after last sample. Repeat with total exactly 0x00400000 → no stop.
- Stall (PATIENCE=2): epoch costs 0x00800000, 0x00900000, 0x00800000 → stop_code=11 after epoch 3. 0x00800000 equal to best counts as non-improving.
- Max epochs (MAX_EPOCH=3, PATIENCE=0): strictly decreasing costs above threshold → stop_code=10, o_epoch_cnt=3. Both converged and max at epoch 3 → 01.
- Gaps/abort: i_valid with 2-cycle gaps → correct count and o_acc_en; start mid-RUN ignored; rst=0 mid-epoch → IDLE, counters 0; start in DONE restarts with o_epoch_cnt=0.
